// File: rtl/obi_mem_responder.sv
// Target end of an OBI-style req/gnt/rvalid port: word-addressed RAM answering
// granted requests in order after RD_LATENCY cycles, with optional LFSR grant throttling.
module obi_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned MEM_WORDS       = 16384,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          GNT_STALL_EN    = 1'b0,
  parameter logic [15:0] STALL_SEED      = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [31:0]           wdata_i,
  output logic                  rvalid_o,
  output logic [31:0]           rdata_o,
  output logic [3:0]            outstanding_o
);

  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam logic [3:0]  MAX_CNT = 4'(MAX_OUTSTANDING);

  if (MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_words
    $error("MEM_WORDS must be a power of 2 (>= 2)");
  end
  if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
    $error("ADDR_WIDTH too small for MEM_WORDS");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_lat
    $error("RD_LATENCY must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 8) begin : g_bad_out
    $error("MAX_OUTSTANDING must be in 1..8");
  end
  if (STALL_SEED == 16'h0000) begin : g_bad_seed
    $error("STALL_SEED must be non-zero");
  end

  logic [31:0]                  mem_q [MEM_WORDS];
  logic [15:0]                  lfsr_q, lfsr_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic [RD_LATENCY-1:0]        vld_q;
  logic [RD_LATENCY-1:0][31:0]  dat_q;
  logic [RD_LATENCY-1:0]        stage_vld;
  logic [RD_LATENCY-1:0][31:0]  stage_dat;
  logic [IDX_W-1:0]             idx;
  logic                         stall;
  logic                         accept;
  logic [31:0]                  tok_dat;
  logic                         unused_addr;

  // Byte offset and bits above the RAM depth are dropped, so addresses alias.
  assign idx         = addr_i[2 +: IDX_W];
  assign unused_addr = ^{addr_i[1:0], addr_i >> (IDX_W + 2)};

  assign stall  = GNT_STALL_EN & lfsr_q[0];
  assign gnt_o  = req_i & ~rst_i & (cnt_q < MAX_CNT) & ~stall;
  assign accept = req_i & gnt_o;

  // Read data is captured at the accept edge; writes answer with zero.
  assign tok_dat = we_i ? 32'h0 : mem_q[idx];

  // Fibonacci LFSR, taps 16,14,13,11.
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  // A slot retiring this cycle is only freed for the next cycle's grant.
  assign cnt_d = cnt_q + {3'b000, accept} - {3'b000, vld_q[RD_LATENCY-1]};

  always_comb begin
    stage_vld    = '0;
    stage_dat    = '0;
    stage_vld[0] = accept;
    stage_dat[0] = tok_dat;
    for (int k = 1; k < RD_LATENCY; k++) begin
      stage_vld[k] = vld_q[k-1];
      stage_dat[k] = dat_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= STALL_SEED;
      cnt_q  <= 4'd0;
      vld_q  <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
      vld_q  <= stage_vld;
    end
  end

  // The final stage doubles as the rdata_o register, so it only loads on a
  // valid token and otherwise holds the last response.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < RD_LATENCY; k++) begin
      if (k == RD_LATENCY - 1) begin
        if (rst_i) begin
          dat_q[k] <= 32'h0;
        end else if (stage_vld[k]) begin
          dat_q[k] <= stage_dat[k];
        end
      end else begin
        dat_q[k] <= stage_dat[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rvalid_o      = vld_q[RD_LATENCY-1];
  assign rdata_o       = dat_q[RD_LATENCY-1];
  assign outstanding_o = cnt_q;

`ifndef SYNTHESIS
  a_rvalid_has_slot: assert property (@(posedge clk_i) disable iff (rst_i)
    rvalid_o |-> (cnt_q != 4'd0));
  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    cnt_q <= MAX_CNT);
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: three instances (latency 1, latency 3 with
// backpressure, LFSR stalls) checked every cycle against a queue-based model.
module tb_obi_mem_responder;

  localparam int NI = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  int lat_m   [NI] = '{1, 3, 2};
  int max_m   [NI] = '{2, 2, 2};
  int words_m [NI] = '{16384, 256, 256};
  bit stall_m [NI] = '{1'b0, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s  [NI];
  logic        req_s  [NI];
  logic        we_s   [NI];
  logic [3:0]  be_s   [NI];
  logic [31:0] addr_s [NI];
  logic [31:0] wd_s   [NI];
  logic        gnt_w  [NI];
  logic        rv_w   [NI];
  logic [31:0] rd_w   [NI];
  logic [3:0]  oc_w   [NI];

  obi_mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(16384), .RD_LATENCY(1),
    .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b0), .STALL_SEED(SEED)) u_dut0 (
    .clk_i(clk), .rst_i(rst_s[0]), .req_i(req_s[0]), .gnt_o(gnt_w[0]),
    .addr_i(addr_s[0]), .we_i(we_s[0]), .be_i(be_s[0]), .wdata_i(wd_s[0]),
    .rvalid_o(rv_w[0]), .rdata_o(rd_w[0]), .outstanding_o(oc_w[0]));

  obi_mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(256), .RD_LATENCY(3),
    .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b0), .STALL_SEED(SEED)) u_dut1 (
    .clk_i(clk), .rst_i(rst_s[1]), .req_i(req_s[1]), .gnt_o(gnt_w[1]),
    .addr_i(addr_s[1]), .we_i(we_s[1]), .be_i(be_s[1]), .wdata_i(wd_s[1]),
    .rvalid_o(rv_w[1]), .rdata_o(rd_w[1]), .outstanding_o(oc_w[1]));

  obi_mem_responder #(.ADDR_WIDTH(32), .MEM_WORDS(256), .RD_LATENCY(2),
    .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b1), .STALL_SEED(SEED)) u_dut2 (
    .clk_i(clk), .rst_i(rst_s[2]), .req_i(req_s[2]), .gnt_o(gnt_w[2]),
    .addr_i(addr_s[2]), .we_i(we_s[2]), .be_i(be_s[2]), .wdata_i(wd_s[2]),
    .rvalid_o(rv_w[2]), .rdata_o(rd_w[2]), .outstanding_o(oc_w[2]));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    int taps [4] = '{16, 14, 13, 11};
    logic fb = 1'b0;
    for (int t = 0; t < 4; t++) fb ^= s[16 - taps[t]];
    return {fb, s[15:1]};
  endfunction

  // Model state: outstanding transactions are queue entries (due cycle, data).
  logic [15:0] lf_m   [NI];
  logic [31:0] last_m [NI];
  int          qdue   [NI][$];
  logic [31:0] qdat   [NI][$];
  logic [31:0] mem_m  [int];
  int          rlog_cyc [NI][$];
  logic [31:0] rlog_dat [NI][$];
  bit          glog_en  [NI];
  bit          glog     [NI][$];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit          eg;
      bit          ev;
      logic [31:0] er;
      logic [31:0] w;
      int          key;
      eg = req_s[i] && !rst_s[i] && (qdue[i].size() < max_m[i]) && !(stall_m[i] && lf_m[i][0]);
      ev = (qdue[i].size() > 0) && (qdue[i][0] == cyc);
      er = ev ? qdat[i][0] : last_m[i];
      chk($sformatf("gnt_dut%0d", i), {31'b0, gnt_w[i]}, {31'b0, eg});
      chk($sformatf("rvalid_dut%0d", i), {31'b0, rv_w[i]}, {31'b0, ev});
      chk($sformatf("rdata_dut%0d", i), rd_w[i], er);
      chk($sformatf("outstanding_dut%0d", i), {28'b0, oc_w[i]}, qdue[i].size());
      if (rv_w[i]) begin
        rlog_cyc[i].push_back(cyc);
        rlog_dat[i].push_back(rd_w[i]);
      end
      if (glog_en[i]) glog[i].push_back(gnt_w[i]);
      if (rst_s[i]) begin
        qdue[i].delete();
        qdat[i].delete();
        lf_m[i]   = SEED;
        last_m[i] = 32'h0;
      end else begin
        lf_m[i] = lfsr_next(lf_m[i]);
        if (ev) begin
          void'(qdue[i].pop_front());
          void'(qdat[i].pop_front());
          last_m[i] = er;
        end
        if (eg) begin
          key = i * 65536 + int'((addr_s[i] >> 2) % words_m[i]);
          w   = mem_m.exists(key) ? mem_m[key] : 32'h0;
          qdue[i].push_back(cyc + lat_m[i]);
          qdat[i].push_back(we_s[i] ? 32'h0 : w);
          if (we_s[i]) begin
            for (int b = 0; b < 4; b++) if (be_s[i][b]) w[8*b +: 8] = wd_s[i][8*b +: 8];
            mem_m[key] = w;
          end
        end
      end
    end
  end

  // Presents a request and keeps req high until granted; returns just after the accept edge.
  task automatic issue(input int i, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       output int waits, output int gcyc);
    req_s[i] = 1'b1; we_s[i] = we; addr_s[i] = addr; be_s[i] = be; wd_s[i] = wd;
    waits = 0;
    gcyc  = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (gnt_w[i]) begin
        gcyc = cyc;
        break;
      end
      waits++;
    end
    if (gcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout_dut%0d: actual no gnt_o in 100 cycles required gnt_o", i);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int i, input int n);
    req_s[i] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, g, gw, rc, cnt_after, saw2;
    logic [31:0] e0 [8];
    bit          g1 [8];
    bit          g2 [4];
    e0 = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h11BB33DD, 32'h0, 32'hCAFEF00D};
    g1 = '{1, 1, 0, 0, 1, 1, 0, 0};
    g2 = '{0, 1, 1, 0};
    for (int i = 0; i < NI; i++) begin
      rst_s[i] = 1'b1; req_s[i] = 1'b0; we_s[i] = 1'b0; be_s[i] = 4'h0;
      addr_s[i] = 32'h0; wd_s[i] = 32'h0; lf_m[i] = SEED; last_m[i] = 32'h0;
      glog_en[i] = 1'b0;
    end

    // Instance 0: reset with req held, then write/read, byte enables, aliasing.
    req_s[0] = 1'b1; we_s[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_s[0] = 1'b0;
    issue(0, 1'b1, 32'h0, 4'h0, 32'h0, w, g);
    chk("first_gnt_after_reset_waits", w, 0);
    issue(0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, w, gw);
    issue(0, 1'b0, 32'h100, 4'hF, 32'h0, w, g);
    issue(0, 1'b1, 32'h200, 4'hF, 32'h11223344, w, g);
    issue(0, 1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, w, g);
    issue(0, 1'b0, 32'h200, 4'h0, 32'h0, w, g);
    issue(0, 1'b1, 32'h0001_0004, 4'hF, 32'hCAFEF00D, w, g);
    issue(0, 1'b0, 32'h0000_0004, 4'h0, 32'h0, w, g);
    idle(0, 4);
    chk("dut0_resp_count", rlog_dat[0].size(), 8);
    for (int k = 0; k < 8 && k < rlog_dat[0].size(); k++)
      chk($sformatf("dut0_resp%0d", k), rlog_dat[0][k], e0[k]);
    if (rlog_cyc[0].size() >= 3) begin
      chk("dut0_wr_resp_cycle", rlog_cyc[0][1], gw + 1);
      chk("dut0_rd_resp_cycle", rlog_cyc[0][2], gw + 2);
    end

    // Instance 1: latency 3, two slots, request held continuously.
    rst_s[1] = 1'b0;
    glog_en[1] = 1'b1;
    for (int k = 0; k < 6; k++) issue(1, 1'b1, 32'(4 * k), 4'hF, 32'hA500_0000 | 32'(k), w, g);
    for (int k = 0; k < 6; k++) issue(1, 1'b0, 32'(4 * k), 4'h0, 32'h0, w, g);
    glog_en[1] = 1'b0;
    idle(1, 6);
    for (int k = 0; k < 8 && k < glog[1].size(); k++)
      chk($sformatf("dut1_gnt_pattern%0d", k), {31'b0, glog[1][k]}, {31'b0, g1[k]});
    chk("dut1_resp_count", rlog_dat[1].size(), 12);
    for (int k = 0; k < 6 && 6 + k < rlog_dat[1].size(); k++)
      chk($sformatf("dut1_read%0d", k), rlog_dat[1][6 + k], 32'hA500_0000 | 32'(k));

    // Instance 2: LFSR stalls, 50 writes then 50 reads, then reset mid-flight.
    rst_s[2] = 1'b0;
    glog_en[2] = 1'b1;
    for (int k = 0; k < 50; k++)
      issue(2, 1'b1, 32'(4 * k), 4'hF, 32'h1000_0000 + 32'(k) * 32'h0123_4567, w, g);
    glog_en[2] = 1'b0;
    for (int k = 0; k < 50; k++) issue(2, 1'b0, 32'(4 * k), 4'h0, 32'h0, w, g);
    for (int k = 0; k < 4 && k < glog[2].size(); k++)
      chk($sformatf("dut2_first_gnts%0d", k), {31'b0, glog[2][k]}, {31'b0, g2[k]});
    for (int k = 0; k < 50 && 50 + k < rlog_dat[2].size(); k++)
      chk($sformatf("dut2_read%0d", k), rlog_dat[2][50 + k], 32'h1000_0000 + 32'(k) * 32'h0123_4567);
    we_s[2] = 1'b0; addr_s[2] = 32'h0; req_s[2] = 1'b1;
    saw2 = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (oc_w[2] == 4'd2) begin
        saw2 = 1;
        break;
      end
    end
    chk("dut2_reached_two_outstanding", saw2, 1);
    @(posedge clk); #1;
    rst_s[2] = 1'b1; req_s[2] = 1'b0;
    rc = cyc;
    repeat (2) @(posedge clk);
    #1;
    rst_s[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    cnt_after = 0;
    for (int k = 0; k < rlog_cyc[2].size(); k++) if (rlog_cyc[2][k] >= rc + 1) cnt_after++;
    chk("dut2_rvalid_after_reset", cnt_after, 0);
    chk("dut2_outstanding_after_reset", {28'b0, oc_w[2]}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
